pulse_gen: RTL and testbench

PULSE_GEN -- requirements
Module: pulse_gen

---
 rtl/pulse_gen.sv | 147 ++++++++++++++
 tb/tb_pulse_gen.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/pulse_gen.sv
// pulse_gen: microsecond-timed pulse interrupter for a gate-drive output.
//
// A parameter strobe loads pending on-time / period words. When enabled,
// the limited values (on-time clamped to MAX_ON_US, period stretched to
// guarantee MIN_OFF_US of off-time) are frozen into the active registers at
// the start of each pulse. The pulse is held for on_act microseconds, then
// the output rests for per_act - on_act microseconds before the next pulse
// may start.
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous active-high reset
//   par_valid  one-cycle strobe qualifying on_us / period_us
//   on_us      requested on-time in microseconds
//   period_us  requested repetition period in microseconds
//   enable     level-sensitive interrupter enable
//   out        registered gate-drive enable
//   clamped    active parameters were altered by the limits
//   state      FSM state: IDLE=0, ON=1, OFF=2
module pulse_gen #(
  parameter int PAR_W      = 16,
  parameter int TICK_DIV   = 50,
  parameter int MAX_ON_US  = 200,
  parameter int MIN_OFF_US = 1000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             par_valid,
  input  logic [PAR_W-1:0] on_us,
  input  logic [PAR_W-1:0] period_us,
  input  logic             enable,
  output logic             out,
  output logic             clamped,
  output logic [1:0]       state
);

  localparam int PRE_W = $clog2(TICK_DIV);
  localparam int EXT_W = PAR_W + 1;
  localparam logic [EXT_W-1:0] MAX_ON  = EXT_W'(MAX_ON_US);
  localparam logic [EXT_W-1:0] MIN_OFF = EXT_W'(MIN_OFF_US);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ON   = 2'd1,
    S_OFF  = 2'd2
  } st_t;

  function automatic logic [EXT_W-1:0] sat_min(input logic [EXT_W-1:0] a,
                                               input logic [EXT_W-1:0] b);
    return (a < b) ? a : b;
  endfunction

  function automatic logic [EXT_W-1:0] sat_max(input logic [EXT_W-1:0] a,
                                               input logic [EXT_W-1:0] b);
    return (a > b) ? a : b;
  endfunction

  st_t              state_q, state_nxt;
  logic [PAR_W-1:0] pend_on, pend_per;
  logic [EXT_W-1:0] on_act, per_act;
  logic [PRE_W-1:0] pre_cnt;
  logic [EXT_W-1:0] us_cnt;

  logic [EXT_W-1:0] on_eff, per_eff, off_us;
  logic             tick, start_ok, on_done, off_done, load;

  // Limits are applied to the pending words continuously; the result is
  // only sampled into the active registers when a pulse begins.
  assign on_eff   = sat_min({1'b0, pend_on}, MAX_ON);
  assign per_eff  = sat_max({1'b0, pend_per}, on_eff + MIN_OFF);
  assign off_us   = per_act - on_act;
  assign tick     = (pre_cnt == PRE_W'(TICK_DIV - 1));
  assign start_ok = enable && (on_eff != '0);
  // ">=" rather than "==" keeps a zero-length phase from running forever.
  assign on_done  = tick && ((us_cnt + EXT_W'(1)) >= on_act);
  assign off_done = tick && ((us_cnt + EXT_W'(1)) >= off_us);
  assign state    = state_q;

  always_comb begin
    state_nxt = state_q;
    load      = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start_ok) begin
          state_nxt = S_ON;
          load      = 1'b1;
        end
      end
      S_ON: begin
        // An enable drop aborts the pulse but still enters a full off-time.
        if (!enable || on_done) state_nxt = S_OFF;
      end
      S_OFF: begin
        if (off_done) begin
          if (start_ok) begin
            state_nxt = S_ON;
            load      = 1'b1;
          end else begin
            state_nxt = S_IDLE;
          end
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      out      <= 1'b0;
      clamped  <= 1'b0;
      pend_on  <= '0;
      pend_per <= '0;
      on_act   <= '0;
      per_act  <= '0;
      pre_cnt  <= '0;
      us_cnt   <= '0;
    end else begin
      state_q <= state_nxt;
      out     <= (state_nxt == S_ON);

      if (par_valid) begin
        pend_on  <= on_us;
        pend_per <= period_us;
      end

      if (load) begin
        on_act  <= on_eff;
        per_act <= per_eff;
        clamped <= (on_eff != {1'b0, pend_on}) || (per_eff != {1'b0, pend_per});
      end

      // Timebase restarts at every phase change so each phase is measured
      // from its own first cycle.
      if ((state_nxt != state_q) || (state_q == S_IDLE)) begin
        pre_cnt <= '0;
        us_cnt  <= '0;
      end else if (tick) begin
        pre_cnt <= '0;
        us_cnt  <= us_cnt + EXT_W'(1);
      end else begin
        pre_cnt <= pre_cnt + PRE_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_pulse_gen.sv
// Testbench for pulse_gen: directed pulse scenarios plus randomized traffic,
// with a timestamp-based reference model feeding a per-cycle scoreboard.
module tb_pulse_gen;

  localparam int PAR_W  = 8;
  localparam int TD     = 4;
  localparam int MAXON  = 5;
  localparam int MINOFF = 2;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             par_valid = 1'b0;
  logic             enable = 1'b0;
  logic [PAR_W-1:0] on_us = '0;
  logic [PAR_W-1:0] period_us = '0;
  logic             out;
  logic             clamped;
  logic [1:0]       state;

  int n_cmp  = 0;
  int n_fail = 0;

  pulse_gen #(
    .PAR_W(PAR_W), .TICK_DIV(TD), .MAX_ON_US(MAXON), .MIN_OFF_US(MINOFF)
  ) dut (
    .clk(clk), .rst(rst), .par_valid(par_valid), .on_us(on_us),
    .period_us(period_us), .enable(enable), .out(out), .clamped(clamped),
    .state(state)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: phases are tracked by the absolute cycle at which they
  // end, derived directly from the microsecond values.
  int     m_state, m_clamp, pend_on, pend_per, act_on, act_per;
  longint cyc = 0;
  longint end_cyc = 0;
  logic [3:0] exp_q[$];

  task automatic begin_pulse(input int oe, input int pe);
    m_state = 1;
    act_on  = oe;
    act_per = pe;
    m_clamp = ((oe != pend_on) || (pe != pend_per)) ? 1 : 0;
    end_cyc = cyc + longint'(oe * TD);
  endtask

  always @(posedge clk) begin : model
    int on_eff, per_eff;
    bit start;
    cyc++;
    if (rst) begin
      m_state = 0; m_clamp = 0; pend_on = 0; pend_per = 0;
      act_on = 0; act_per = 0;
    end else begin
      on_eff  = (pend_on < MAXON) ? pend_on : MAXON;
      per_eff = (pend_per > on_eff + MINOFF) ? pend_per : on_eff + MINOFF;
      start   = enable && (on_eff != 0);
      case (m_state)
        0: if (start) begin_pulse(on_eff, per_eff);
        1: if (!enable || cyc == end_cyc) begin
             m_state = 2;
             end_cyc = cyc + longint'((act_per - act_on) * TD);
           end
        default: if (cyc == end_cyc) begin
             if (start) begin_pulse(on_eff, per_eff);
             else m_state = 0;
           end
      endcase
      if (par_valid) begin
        pend_on  = int'(on_us);
        pend_per = int'(period_us);
      end
    end
    exp_q.push_back({2'(m_state), (m_state == 1), 1'(m_clamp)});
  end

  // Monitor: compares the registered outputs once per cycle on the falling edge.
  always @(negedge clk) begin : monitor
    logic [3:0] e;
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      check("cycle{state,out,clamped}", {28'd0, state, out, clamped}, {28'd0, e});
    end
  end

  task automatic step;
    @(negedge clk);
    #1;
  endtask

  task automatic pv(input int o, input int p);
    on_us     = PAR_W'(o);
    period_us = PAR_W'(p);
    par_valid = 1'b1;
    step;
    par_valid = 1'b0;
  endtask

  // Skips any pulse in progress, then measures the next full high and low run.
  task automatic measure(input string name, input int ehi, input int elo);
    int hi = 0, lo = 0, guard = 0;
    while (out === 1'b1 && guard < 400) begin step; guard++; end
    while (out !== 1'b1 && guard < 400) begin step; guard++; end
    while (out === 1'b1 && guard < 400) begin hi++; step; guard++; end
    while (out !== 1'b1 && guard < 400) begin lo++; step; guard++; end
    check({name, "_high"}, hi, ehi);
    check({name, "_low"}, lo, elo);
  endtask

  initial begin
    int cnt;
    step; step;
    check("reset_state", state, 0);
    check("reset_out", out, 0);
    check("reset_clamped", clamped, 0);
    rst = 1'b0;
    step;

    // Basic repeating pulse.
    pv(3, 10);
    enable = 1'b1;
    measure("on3_per10", 12, 28);
    check("on3_per10_clamped", clamped, 0);

    // New parameters mid-pulse apply to the following pulse only.
    pv(1, 10);
    measure("midpulse_update", 4, 36);

    // On-time clamped and period stretched.
    pv(9, 6);
    measure("clamp", 20, 8);
    check("clamp_flag", clamped, 1);

    // Abort on enable drop.
    pv(3, 10);
    measure("abort_sync", 12, 28);
    repeat (4) step;
    enable = 1'b0;
    step;
    check("abort_out", out, 0);
    check("abort_state", state, 2);
    cnt = 0;
    while (state == 2'd2 && cnt < 100) begin cnt++; step; end
    check("abort_off_len", cnt, 28);
    check("abort_to_idle", state, 0);

    // Asynchronous reset mid-pulse.
    enable = 1'b1;
    cnt = 0;
    while (out !== 1'b1 && cnt < 20) begin cnt++; step; end
    check("pre_reset_out", out, 1);
    step; step;
    rst = 1'b1;
    #1;
    check("async_rst_out", out, 0);
    check("async_rst_state", state, 0);
    step; step;
    rst = 1'b0;
    cnt = 0;
    repeat (60) begin step; if (out === 1'b1) cnt++; end
    check("post_reset_no_pulse", cnt, 0);

    // Zero on-time never pulses.
    pv(0, 10);
    repeat (20) step;
    check("zero_on_out", out, 0);
    check("zero_on_state", state, 0);

    // Randomized traffic against the model.
    repeat (3000) begin
      par_valid = ($urandom_range(0, 15) == 0);
      on_us     = PAR_W'($urandom_range(0, 9));
      period_us = PAR_W'($urandom_range(0, 24));
      if ($urandom_range(0, 39) == 0) enable = ~enable;
      rst = ($urandom_range(0, 599) == 0);
      step;
    end
    rst = 1'b0;
    par_valid = 1'b0;
    repeat (3) step;

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
    $finish;
  end

endmodule
